alien_wave_controller: RTL and testbench

ALIEN_WAVE_CONTROLLER -- requirements
Module: alien_wave_controller

---
 rtl/alien_wave_controller.sv | 174 +++++++++++++++++
 tb/tb_alien_wave_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_wave_controller.sv
// ---------------------------------------------------------------------------
// alien_wave_controller
//
// Game-flow sequencer for the alien-invaders screen. Tracks the alien count
// of the current wave, the player's remaining lives and the wave number. It
// also decides when a wave is cleared, when the game is over and when a new
// game may start. The between-wave pause and the game-over hold are measured
// in video frames.
//
// Ports:
//   clk                 system clock, all logic on the rising edge
//   resetN              synchronous reset, active high (1 = reset)
//   startOfFrame        one-cycle pulse per video frame
//   startKey            start request (level), only honoured while idle
//   alienHit            one-cycle pulse per alien destroyed
//   playerHit           one-cycle pulse per player hit
//   alienReachedBottom  level, alien matrix touched the bottom border
//   playGame            high while a wave is played or being cleared
//   matrixDefeated      one-cycle pulse on the first cycle of a wave clear
//   level               current wave number, 0-based, saturating
//   lives               remaining lives
//   aliensLeft          aliens remaining in the current wave
//   gameOver            high while the game-over screen is held
// ---------------------------------------------------------------------------
module alien_wave_controller #(
   parameter int ALIEN_COUNT           = 32,
   parameter int START_LIVES           = 3,
   parameter int CLEAR_DELAY_FRAMES    = 60,
   parameter int GAMEOVER_DELAY_FRAMES = 120,
   parameter int MAX_LEVEL             = 7
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       startKey,
   input  logic       alienHit,
   input  logic       playerHit,
   input  logic       alienReachedBottom,
   output logic       playGame,
   output logic       matrixDefeated,
   output logic [2:0] level,
   output logic [1:0] lives,
   output logic [5:0] aliensLeft,
   output logic       gameOver
);

   // The frame counter is shared by both timed states, so it is sized for
   // the longer of the two delays.
   localparam int MAX_DELAY = (CLEAR_DELAY_FRAMES > GAMEOVER_DELAY_FRAMES) ?
                              CLEAR_DELAY_FRAMES : GAMEOVER_DELAY_FRAMES;
   localparam int FW = $clog2(MAX_DELAY + 1);

   localparam logic [5:0]    ALIENS_INIT = 6'(ALIEN_COUNT);
   localparam logic [1:0]    LIVES_INIT  = 2'(START_LIVES);
   localparam logic [2:0]    LEVEL_TOP   = 3'(MAX_LEVEL);
   localparam logic [FW-1:0] CLEAR_LAST  = FW'(CLEAR_DELAY_FRAMES - 1);
   localparam logic [FW-1:0] OVER_LAST   = FW'(GAMEOVER_DELAY_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      CLEAR,
      GAMEOVER
   } stateT;

   stateT         state;
   logic [FW-1:0] frameCount;

   logic [5:0] aliensAfterHit;
   logic [1:0] livesAfterHit;
   logic [2:0] nextLevel;
   logic       waveCleared;
   logic       lastLifeLost;
   logic       gameOverCause;

   // Outcome of the current PLAY cycle, computed from the hit inputs. An
   // alien hit and a non-fatal player hit in the same cycle are both applied.
   // A hit on an empty wave is dropped rather than wrapping the count.
   // Losing the last life or reaching the bottom ends the game. That cause
   // outranks a simultaneous wave clear.
   always_comb begin
      aliensAfterHit = aliensLeft;
      waveCleared    = 1'b0;
      livesAfterHit  = lives;
      lastLifeLost   = 1'b0;
      nextLevel      = (level >= LEVEL_TOP) ? LEVEL_TOP : level + 3'd1;
      if (alienHit && (aliensLeft != 6'd0)) begin
         aliensAfterHit = aliensLeft - 6'd1;
         waveCleared    = (aliensLeft == 6'd1);
      end
      if (playerHit) begin
         if (lives > 2'd1) begin
            livesAfterHit = lives - 2'd1;
         end else begin
            livesAfterHit = 2'd0;
            lastLifeLost  = 1'b1;
         end
      end
      gameOverCause = alienReachedBottom || lastLifeLost;
   end

   // Main game sequencer. All outputs are registered and change together
   // with the state. matrixDefeated defaults low each cycle, so it is high
   // only on the cycle right after the transition into CLEAR. The frame
   // counter is zeroed on every state entry. It advances only on
   // startOfFrame pulses in the two timed states.
   always_ff @(posedge clk) begin
      if (resetN) begin
         state          <= IDLE;
         playGame       <= 1'b0;
         matrixDefeated <= 1'b0;
         gameOver       <= 1'b0;
         level          <= 3'd0;
         lives          <= LIVES_INIT;
         aliensLeft     <= ALIENS_INIT;
         frameCount     <= '0;
      end else begin
         matrixDefeated <= 1'b0;
         case (state)
            IDLE: begin
               if (startKey) begin
                  state      <= PLAY;
                  playGame   <= 1'b1;
                  aliensLeft <= ALIENS_INIT;
                  lives      <= LIVES_INIT;
                  level      <= 3'd0;
                  frameCount <= '0;
               end
            end
            PLAY: begin
               aliensLeft <= aliensAfterHit;
               lives      <= livesAfterHit;
               if (gameOverCause) begin
                  state      <= GAMEOVER;
                  playGame   <= 1'b0;
                  gameOver   <= 1'b1;
                  frameCount <= '0;
               end else if (waveCleared) begin
                  state          <= CLEAR;
                  matrixDefeated <= 1'b1;
                  frameCount     <= '0;
               end
            end
            CLEAR: begin
               if (startOfFrame) begin
                  if (frameCount == CLEAR_LAST) begin
                     state      <= PLAY;
                     aliensLeft <= ALIENS_INIT;
                     level      <= nextLevel;
                     frameCount <= '0;
                  end else begin
                     frameCount <= frameCount + 1'b1;
                  end
               end
            end
            GAMEOVER: begin
               if (startOfFrame) begin
                  if (frameCount == OVER_LAST) begin
                     state      <= IDLE;
                     gameOver   <= 1'b0;
                     frameCount <= '0;
                  end else begin
                     frameCount <= frameCount + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alien_wave_controller.sv
// ---------------------------------------------------------------------------
// tb_alien_wave_controller
//
// Self-checking bench for alien_wave_controller with default parameters.
// A fixed vector table is followed by hand-written multi-cycle sequences and
// a randomized run. Every cycle is also compared against a behavioural
// game model kept in this file.
// ---------------------------------------------------------------------------
module tb_alien_wave_controller;

   localparam int N_ALIENS  = 32;
   localparam int N_LIVES   = 3;
   localparam int CLEAR_FR  = 60;
   localparam int OVER_FR   = 120;
   localparam int TOP_LEVEL = 7;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       startKey = 1'b0;
   logic       alienHit = 1'b0;
   logic       playerHit = 1'b0;
   logic       alienReachedBottom = 1'b0;
   logic       playGame;
   logic       matrixDefeated;
   logic [2:0] level;
   logic [1:0] lives;
   logic [5:0] aliensLeft;
   logic       gameOver;

   int testCount = 0;
   int failCount = 0;
   int defeatSeen = 0;

   // Behavioural model: the game phase is a plain name, the counts are plain
   // integers.
   string mPhase = "idle";
   int    mAliens = N_ALIENS;
   int    mLives = N_LIVES;
   int    mLevel = 0;
   int    mFrames = 0;
   bit    mDefeat = 1'b0;

   typedef struct {
      logic       rst, sof, sk, ah, ph, bot;
      logic       expPlay, expDef;
      logic [2:0] expLevel;
      logic [1:0] expLives;
      logic [5:0] expAliens;
      logic       expOver;
   } vecT;

   vecT vecs [13];

   alien_wave_controller dut (
      .clk                (clk),
      .resetN             (resetN),
      .startOfFrame       (startOfFrame),
      .startKey           (startKey),
      .alienHit           (alienHit),
      .playerHit          (playerHit),
      .alienReachedBottom (alienReachedBottom),
      .playGame           (playGame),
      .matrixDefeated     (matrixDefeated),
      .level              (level),
      .lives              (lives),
      .aliensLeft         (aliensLeft),
      .gameOver           (gameOver)
   );

   always #5 clk = ~clk;

   // Advance the game model by one clock using the inputs of that clock.
   function automatic void modelStep(input logic r, sof, sk, ah, ph, bot);
      bit cleared;
      bit dead;
      mDefeat = 1'b0;
      if (r) begin
         mPhase  = "idle";
         mAliens = N_ALIENS;
         mLives  = N_LIVES;
         mLevel  = 0;
         mFrames = 0;
      end else if (mPhase == "idle") begin
         if (sk) begin
            mPhase  = "play";
            mAliens = N_ALIENS;
            mLives  = N_LIVES;
            mLevel  = 0;
            mFrames = 0;
         end
      end else if (mPhase == "play") begin
         cleared = 1'b0;
         dead    = bot;
         if (ah && mAliens > 0) begin
            mAliens = mAliens - 1;
            cleared = (mAliens == 0);
         end
         if (ph) begin
            if (mLives > 1) begin
               mLives = mLives - 1;
            end else begin
               mLives = 0;
               dead   = 1'b1;
            end
         end
         if (dead) begin
            mPhase  = "over";
            mFrames = 0;
         end else if (cleared) begin
            mPhase  = "clear";
            mDefeat = 1'b1;
            mFrames = 0;
         end
      end else if (mPhase == "clear") begin
         if (sof) mFrames = mFrames + 1;
         if (mFrames == CLEAR_FR) begin
            mPhase  = "play";
            mAliens = N_ALIENS;
            mLevel  = (mLevel + 1 > TOP_LEVEL) ? TOP_LEVEL : mLevel + 1;
            mFrames = 0;
         end
      end else begin
         if (sof) mFrames = mFrames + 1;
         if (mFrames == OVER_FR) begin
            mPhase  = "idle";
            mFrames = 0;
         end
      end
   endfunction

   // Compare all outputs against the given expected values.
   task automatic checkOutput(input string name, input logic ePlay, eDef,
                              input logic [2:0] eLevel, input logic [1:0] eLives,
                              input logic [5:0] eAliens, input logic eOver);
      testCount++;
      if (playGame !== ePlay || matrixDefeated !== eDef || level !== eLevel ||
          lives !== eLives || aliensLeft !== eAliens || gameOver !== eOver) begin
         failCount++;
         $display("[TB] FAIL %s: got play=%b def=%b lvl=%0d lives=%0d aliens=%0d over=%b, expected play=%b def=%b lvl=%0d lives=%0d aliens=%0d over=%b",
                  name, playGame, matrixDefeated, level, lives, aliensLeft, gameOver,
                  ePlay, eDef, eLevel, eLives, eAliens, eOver);
      end
   endtask

   task automatic checkValue(input string name, input int got, input int exp);
      testCount++;
      if (got != exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, (mPhase == "play" || mPhase == "clear"), mDefeat,
                  3'(mLevel), 2'(mLives), 6'(mAliens), (mPhase == "over"));
   endtask

   // Drive one cycle of inputs, let the DUT and model take the edge, then
   // sample just after it and compare against the model.
   task automatic applyStimulus(input logic r, sof, sk, ah, ph, bot);
      resetN             = r;
      startOfFrame       = sof;
      startKey           = sk;
      alienHit           = ah;
      playerHit          = ph;
      alienReachedBottom = bot;
      @(posedge clk);
      modelStep(r, sof, sk, ah, ph, bot);
      #1;
      if (matrixDefeated === 1'b1) defeatSeen++;
      checkModel("model");
   endtask

   task automatic startGame();
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
   endtask

   task automatic hitAliens(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0, 0);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      int d0;
      // Vector table: rst sof sk ah ph bot | play def lvl lives aliens over
      vecs[0]  = '{1,0,0,0,0,0, 0,0,0,3,32,0};
      vecs[1]  = '{0,0,1,0,0,0, 1,0,0,3,32,0};
      vecs[2]  = '{0,1,0,1,0,0, 1,0,0,3,31,0};
      vecs[3]  = '{0,0,0,1,1,0, 1,0,0,2,30,0};
      vecs[4]  = '{0,0,1,0,0,0, 1,0,0,2,30,0};
      vecs[5]  = '{0,0,0,0,1,0, 1,0,0,1,30,0};
      vecs[6]  = '{0,0,0,0,0,1, 0,0,0,1,30,1};
      vecs[7]  = '{0,1,1,1,1,0, 0,0,0,1,30,1};
      vecs[8]  = '{1,0,0,0,0,0, 0,0,0,3,32,0};
      vecs[9]  = '{0,0,0,1,0,0, 0,0,0,3,32,0};
      vecs[10] = '{0,0,1,0,0,0, 1,0,0,3,32,0};
      vecs[11] = '{0,0,0,1,0,1, 0,0,0,3,31,1};
      vecs[12] = '{1,0,0,0,0,0, 0,0,0,3,32,0};

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].sof, vecs[i].sk, vecs[i].ah,
                       vecs[i].ph, vecs[i].bot);
         checkOutput($sformatf("vector%0d", i), vecs[i].expPlay, vecs[i].expDef,
                     vecs[i].expLevel, vecs[i].expLives, vecs[i].expAliens,
                     vecs[i].expOver);
      end

      // Start and a full wave clear followed by the 60-frame pause.
      startGame();
      checkOutput("start", 1, 0, 0, 3, 32, 0);
      d0 = defeatSeen;
      hitAliens(31);
      checkOutput("oneLeft", 1, 0, 0, 3, 1, 0);
      hitAliens(1);
      checkOutput("waveCleared", 1, 1, 0, 3, 0, 0);
      applyStimulus(0, 0, 1, 1, 1, 1);
      checkOutput("clearIgnoresInputs", 1, 0, 0, 3, 0, 0);
      for (int i = 0; i < CLEAR_FR - 1; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 1, 0, 0);
      end
      checkOutput("clearFrame59", 1, 0, 0, 3, 0, 0);
      frames(1);
      checkOutput("nextWave", 1, 0, 1, 3, 32, 0);
      checkValue("defeatPulseCount", defeatSeen - d0, 1);

      // Three player hits end the game, then the 120-frame hold.
      startGame();
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("lives2", 1, 0, 0, 2, 32, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("lives1", 1, 0, 0, 1, 32, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("lives0", 0, 0, 0, 0, 32, 1);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("overIgnoresStart", 0, 0, 0, 0, 32, 1);
      frames(OVER_FR - 1);
      checkOutput("overFrame119", 0, 0, 0, 0, 32, 1);
      frames(1);
      checkOutput("backToIdle", 0, 0, 0, 0, 32, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("restart", 1, 0, 0, 3, 32, 0);

      // Last alien and bottom in the same cycle: game over wins.
      startGame();
      hitAliens(31);
      d0 = defeatSeen;
      applyStimulus(0, 0, 0, 1, 0, 1);
      checkOutput("hitAndBottom", 0, 0, 0, 3, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue("noDefeatOnConflict", defeatSeen - d0, 0);

      // Eight waves: level saturates at 7.
      startGame();
      for (int w = 0; w < 8; w++) begin
         hitAliens(32);
         frames(CLEAR_FR);
         checkValue($sformatf("levelWave%0d", w), int'(level),
                    (w + 1 > TOP_LEVEL) ? TOP_LEVEL : w + 1);
      end

      // Reset in the middle of a clear pause.
      startGame();
      hitAliens(32);
      frames(30);
      checkOutput("midClear", 1, 0, 0, 3, 0, 0);
      applyStimulus(1, 1, 1, 1, 1, 1);
      checkOutput("resetMidClear", 0, 0, 0, 3, 32, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("idleAfterReset", 0, 0, 0, 3, 32, 0);

      // Randomized play against the model.
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6000; i++) begin
         applyStimulus($urandom_range(0, 299) == 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 1) == 0,
                       $urandom_range(0, 24) == 0,
                       $urandom_range(0, 149) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
